avalon_dualport_ram: RTL and testbench

- Parametrised true dual-port on-chip RAM for Avalon-MM. Successor to the fixed 32-bit, 25000-word, single-port program/data memory.
- Port s1 serves the Nios II data master. Port s2 serves the acquisition/DMA side, so sample buffers can be filled while the CPU reads them.
- Adds configurable read latency with readdatavalid, non-power-of-two depth bounds checking, write-collision arbitration, and a collision counter.

---
 rtl/avalon_ram_pkg.sv | 15 +
 rtl/dp_ram_core.sv | 49 ++++
 rtl/avalon_dualport_ram.sv | 160 ++++++++++++++++
 tb/tb_avalon_dualport_ram.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_ram_pkg.sv
// Shared constants and helpers for the Avalon-MM dual-port RAM.
// Byte-lane geometry and read-latency legality live here so every file agrees.
package avalon_ram_pkg;

    localparam int BYTE_W = 8;

    function automatic int be_width(input int data_width);
        return data_width / BYTE_W;
    endfunction

    function automatic bit latency_ok(input int read_latency);
        return (read_latency == 1) || (read_latency == 2);
    endfunction

endpackage

// File: rtl/dp_ram_core.sv
// Inferred true dual-port array with per-lane write enables and one registered read per port.
// Reads sample the array before same-edge writes land, so a mixed-port same-address access returns old data.
module dp_ram_core
    import avalon_ram_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH      = 25000,
    parameter int    ADDR_WIDTH = 15,
    parameter string INIT_FILE  = ""
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            a_rd,
    input  logic                            a_we,
    input  logic [ADDR_WIDTH-1:0]           a_addr,
    input  logic [be_width(DATA_WIDTH)-1:0] a_be,
    input  logic [DATA_WIDTH-1:0]           a_wdata,
    output logic [DATA_WIDTH-1:0]           a_q,
    input  logic                            b_rd,
    input  logic                            b_we,
    input  logic [ADDR_WIDTH-1:0]           b_addr,
    input  logic [be_width(DATA_WIDTH)-1:0] b_be,
    input  logic [DATA_WIDTH-1:0]           b_wdata,
    output logic [DATA_WIDTH-1:0]           b_q
);

    localparam int BE_W = be_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The top never enables both writes to the same address in one cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (a_we && a_be[i]) mem[a_addr][i*BYTE_W +: BYTE_W] <= a_wdata[i*BYTE_W +: BYTE_W];
            if (b_we && b_be[i]) mem[b_addr][i*BYTE_W +: BYTE_W] <= b_wdata[i*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (a_rd) a_q <= mem[a_addr];
            if (b_rd) b_q <= mem[b_addr];
        end
    end

endmodule

// File: rtl/avalon_dualport_ram.sv
// Avalon-MM true dual-port RAM: stall/accept, range check, s1-wins write collisions,
// 1- or 2-cycle read pipelines with readdatavalid, and a saturating s2 collision counter.
module avalon_dualport_ram
    import avalon_ram_pkg::*;
#(
    parameter int    DATA_WIDTH   = 32,
    parameter int    DEPTH        = 25000,
    parameter int    ADDR_WIDTH   = 15,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clken,
    input  logic                            reset_req,
    input  logic [ADDR_WIDTH-1:0]           s1_address,
    input  logic                            s1_chipselect,
    input  logic                            s1_read,
    input  logic                            s1_write,
    input  logic [be_width(DATA_WIDTH)-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]           s1_writedata,
    output logic [DATA_WIDTH-1:0]           s1_readdata,
    output logic                            s1_readdatavalid,
    output logic                            s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]           s2_address,
    input  logic                            s2_chipselect,
    input  logic                            s2_read,
    input  logic                            s2_write,
    input  logic [be_width(DATA_WIDTH)-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]           s2_writedata,
    output logic [DATA_WIDTH-1:0]           s2_readdata,
    output logic                            s2_readdatavalid,
    output logic                            s2_waitrequest,
    output logic [15:0]                     s2_collisions
);

    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("avalon_dualport_ram: READ_LATENCY must be 1 or 2");
    end
    if (ADDR_WIDTH != $clog2(DEPTH) || DEPTH < 2 || (DATA_WIDTH % BYTE_W) != 0) begin : g_bad_geometry
        $error("avalon_dualport_ram: inconsistent DATA_WIDTH/DEPTH/ADDR_WIDTH");
    end

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    // Handshake: a request is taken on a clock edge when chipselect and read or write
    // are high and waitrequest is low; write wins over a simultaneous read. Read data is
    // qualified by readdatavalid, which is masked (and the pipeline frozen) while stalled.
    logic stall;
    assign stall          = ~clken | reset_req;
    assign s1_waitrequest = stall;
    assign s2_waitrequest = stall;

    logic s1_acc_wr, s1_acc_rd, s1_in_range, s1_we, s1_rd_en;
    logic s2_acc_wr, s2_acc_rd, s2_in_range, s2_we, s2_rd_en;
    logic collision;

    assign s1_acc_wr   = s1_chipselect & s1_write & ~stall;
    assign s1_acc_rd   = s1_chipselect & s1_read & ~s1_write & ~stall;
    assign s1_in_range = {1'b0, s1_address} < DEPTH_LIM;
    assign s2_acc_wr   = s2_chipselect & s2_write & ~stall;
    assign s2_acc_rd   = s2_chipselect & s2_read & ~s2_write & ~stall;
    assign s2_in_range = {1'b0, s2_address} < DEPTH_LIM;

    // An s2 write that lands on the word s1 is writing this cycle is dropped in full.
    assign collision = s1_acc_wr & s1_in_range & s2_acc_wr & s2_in_range & (s1_address == s2_address);
    assign s1_we     = s1_acc_wr & s1_in_range;
    assign s2_we     = s2_acc_wr & s2_in_range & ~collision;
    assign s1_rd_en  = s1_acc_rd & s1_in_range;
    assign s2_rd_en  = s2_acc_rd & s2_in_range;

    logic [DATA_WIDTH-1:0] s1_q, s2_q;

    dp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .a_rd    (s1_rd_en),
        .a_we    (s1_we),
        .a_addr  (s1_address),
        .a_be    (s1_byteenable),
        .a_wdata (s1_writedata),
        .a_q     (s1_q),
        .b_rd    (s2_rd_en),
        .b_we    (s2_we),
        .b_addr  (s2_address),
        .b_be    (s2_byteenable),
        .b_wdata (s2_writedata),
        .b_q     (s2_q)
    );

    logic s1_v1, s1_oor1, s2_v1, s2_oor1;
    logic [DATA_WIDTH-1:0] s1_d1, s2_d1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v1   <= 1'b0;
            s1_oor1 <= 1'b0;
            s2_v1   <= 1'b0;
            s2_oor1 <= 1'b0;
        end else if (!stall) begin
            s1_v1 <= s1_acc_rd;
            s2_v1 <= s2_acc_rd;
            if (s1_acc_rd) s1_oor1 <= ~s1_in_range;
            if (s2_acc_rd) s2_oor1 <= ~s2_in_range;
        end
    end

    // Out-of-range reads never touch the array; their data is forced to zero here.
    assign s1_d1 = s1_oor1 ? '0 : s1_q;
    assign s2_d1 = s2_oor1 ? '0 : s2_q;

    logic s1_v_last, s2_v_last;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s1_v2, s2_v2;
        logic [DATA_WIDTH-1:0] s1_d2, s2_d2;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_v2 <= 1'b0;
                s2_v2 <= 1'b0;
                s1_d2 <= '0;
                s2_d2 <= '0;
            end else if (!stall) begin
                s1_v2 <= s1_v1;
                s2_v2 <= s2_v1;
                s1_d2 <= s1_d1;
                s2_d2 <= s2_d1;
            end
        end

        assign s1_v_last   = s1_v2;
        assign s2_v_last   = s2_v2;
        assign s1_readdata = s1_d2;
        assign s2_readdata = s2_d2;
    end else begin : g_lat1
        assign s1_v_last   = s1_v1;
        assign s2_v_last   = s2_v1;
        assign s1_readdata = s1_d1;
        assign s2_readdata = s2_d1;
    end

    // A held valid is shown only in an unstalled cycle, so it is delivered exactly once.
    assign s1_readdatavalid = s1_v_last & ~stall;
    assign s2_readdatavalid = s2_v_last & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_collisions <= '0;
        end else if (collision && s2_collisions != 16'hFFFF) begin
            s2_collisions <= s2_collisions + 16'd1;
        end
    end

endmodule

// File: tb/tb_avalon_dualport_ram.sv
// Directed bench: two instances (READ_LATENCY 1 and 2) share stimulus; a vector table
// plus hand sequences for collisions, mixed-port access, stalls, reset and saturation.
module tb_avalon_dualport_ram;

    localparam int DW = 32;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic reset, clken, reset_req;
    logic [AW-1:0] s1_address, s2_address;
    logic s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [3:0] s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata, s2_writedata;

    logic [DW-1:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
    logic a_s1_v, a_s2_v, b_s1_v, b_s2_v;
    logic a_s1_wr, a_s2_wr, b_s1_wr, b_s2_wr;
    logic [15:0] a_coll, b_coll;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    avalon_dualport_ram #(.DATA_WIDTH(DW), .DEPTH(25000), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(a_s1_rd), .s1_readdatavalid(a_s1_v), .s1_waitrequest(a_s1_wr),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(a_s2_rd), .s2_readdatavalid(a_s2_v), .s2_waitrequest(a_s2_wr),
        .s2_collisions(a_coll)
    );

    avalon_dualport_ram #(.DATA_WIDTH(DW), .DEPTH(25000), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(b_s1_rd), .s1_readdatavalid(b_s1_v), .s1_waitrequest(b_s1_wr),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(b_s2_rd), .s2_readdatavalid(b_s2_v), .s2_waitrequest(b_s2_wr),
        .s2_collisions(b_coll)
    );

    typedef struct {
        bit            is_wr;
        int            port;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0;
    endtask

    task automatic set_req(input int port, input bit wr, input bit rd, input logic [AW-1:0] addr,
                           input logic [3:0] be, input logic [DW-1:0] data);
        if (port == 1) begin
            s1_chipselect = 1; s1_write = wr; s1_read = rd;
            s1_address = addr; s1_byteenable = be; s1_writedata = data;
        end else begin
            s2_chipselect = 1; s2_write = wr; s2_read = rd;
            s2_address = addr; s2_byteenable = be; s2_writedata = data;
        end
    endtask

    task automatic do_write(input int port, input logic [AW-1:0] addr, input logic [3:0] be,
                            input logic [DW-1:0] data);
        set_req(port, 1, 0, addr, be, data);
        step();
        idle();
    endtask

    // Cycle after the accepting edge: latency-1 instance shows data, latency-2 does not yet.
    task automatic check_lat1(input string name, input int port, input logic [DW-1:0] exp);
        if (port == 1) begin
            check({name, " L1 valid"}, DW'(a_s1_v), 1);
            check({name, " L1 data"}, a_s1_rd, exp);
            check({name, " L2 early valid"}, DW'(b_s1_v), 0);
        end else begin
            check({name, " L1 valid"}, DW'(a_s2_v), 1);
            check({name, " L1 data"}, a_s2_rd, exp);
            check({name, " L2 early valid"}, DW'(b_s2_v), 0);
        end
    endtask

    task automatic check_lat2(input string name, input int port, input logic [DW-1:0] exp);
        if (port == 1) begin
            check({name, " L2 valid"}, DW'(b_s1_v), 1);
            check({name, " L2 data"}, b_s1_rd, exp);
            check({name, " L1 single valid"}, DW'(a_s1_v), 0);
        end else begin
            check({name, " L2 valid"}, DW'(b_s2_v), 1);
            check({name, " L2 data"}, b_s2_rd, exp);
            check({name, " L1 single valid"}, DW'(a_s2_v), 0);
        end
    endtask

    task automatic do_read(input string name, input int port, input logic [AW-1:0] addr,
                           input logic [DW-1:0] exp);
        set_req(port, 0, 1, addr, 4'hF, '0);
        step();
        idle();
        check_lat1(name, port, exp);
        step();
        check_lat2(name, port, exp);
    endtask

    initial begin
        reset = 1; clken = 1; reset_req = 0;
        s1_address = '0; s2_address = '0; s1_byteenable = '0; s2_byteenable = '0;
        s1_writedata = '0; s2_writedata = '0;
        idle();

        vecs[0]  = '{1, 1, 15'd5,     4'hF, 32'hDEADBEEF};
        vecs[1]  = '{0, 2, 15'd5,     4'hF, 32'hDEADBEEF};
        vecs[2]  = '{1, 1, 15'd3,     4'hF, 32'h11223344};
        vecs[3]  = '{1, 1, 15'd3,     4'h5, 32'hAABBCCDD};
        vecs[4]  = '{0, 1, 15'd3,     4'hF, 32'h11BB33DD};
        vecs[5]  = '{1, 2, 15'd24999, 4'hF, 32'h12345678};
        vecs[6]  = '{1, 1, 15'd25000, 4'hF, 32'hFFFFFFFF};
        vecs[7]  = '{0, 2, 15'd25000, 4'hF, 32'h00000000};
        vecs[8]  = '{0, 1, 15'd24999, 4'hF, 32'h12345678};
        vecs[9]  = '{0, 1, 15'd5,     4'hF, 32'hDEADBEEF};
        vecs[10] = '{1, 2, 15'd0,     4'hA, 32'hCAFEF00D};
        vecs[11] = '{1, 2, 15'd0,     4'h5, 32'h01020304};
        vecs[12] = '{0, 1, 15'd0,     4'hF, 32'hCA02F004};
        vecs[13] = '{0, 2, 15'd3,     4'hF, 32'h11BB33DD};

        repeat (3) step();
        check("reset s1 valid", DW'(a_s1_v | b_s1_v), 0);
        check("reset s2 valid", DW'(a_s2_v | b_s2_v), 0);
        check("reset s1 data", a_s1_rd | b_s1_rd, 0);
        check("reset s2 data", a_s2_rd | b_s2_rd, 0);
        check("reset collisions", DW'(a_coll | b_coll), 0);
        reset = 0;
        step();

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].port, vecs[i].addr, vecs[i].be, vecs[i].data);
            else do_read($sformatf("vec%0d", i), vecs[i].port, vecs[i].addr, vecs[i].data);
        end

        // Write collision at addr 7: s1 wins, counter bumps once.
        set_req(1, 1, 0, 15'd7, 4'hF, 32'h1);
        set_req(2, 1, 0, 15'd7, 4'hF, 32'h2);
        step();
        idle();
        check("collision count L1", DW'(a_coll), 1);
        check("collision count L2", DW'(b_coll), 1);
        do_read("collision data", 2, 15'd7, 32'h1);

        // Mixed-port read during write returns old data, then new data.
        do_write(1, 15'd9, 4'hF, 32'hA);
        set_req(1, 1, 0, 15'd9, 4'hF, 32'hB);
        set_req(2, 0, 1, 15'd9, 4'hF, '0);
        step();
        idle();
        check_lat1("mixed old", 2, 32'hA);
        step();
        check_lat2("mixed old", 2, 32'hA);
        do_read("mixed new", 2, 15'd9, 32'hB);

        // Back-to-back reads give a valid every cycle.
        set_req(1, 0, 1, 15'd3, 4'hF, '0);
        step();
        set_req(1, 0, 1, 15'd5, 4'hF, '0);
        step();
        idle();
        check("b2b L1 valid 2", DW'(a_s1_v), 1);
        check("b2b L1 data 2", a_s1_rd, 32'hDEADBEEF);
        check("b2b L2 valid 1", DW'(b_s1_v), 1);
        check("b2b L2 data 1", b_s1_rd, 32'h11BB33DD);
        step();
        check("b2b L2 valid 2", DW'(b_s1_v), 1);
        check("b2b L2 data 2", b_s1_rd, 32'hDEADBEEF);
        step();
        check("b2b drained", DW'(a_s1_v | b_s1_v), 0);

        // clken low for 3 cycles right after a read is accepted.
        set_req(1, 0, 1, 15'd5, 4'hF, '0);
        step();
        idle();
        clken = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d waitrequest", c), DW'({a_s1_wr, a_s2_wr, b_s1_wr, b_s2_wr}), 4'hF);
            check($sformatf("stall%0d valid", c), DW'(a_s1_v | b_s1_v), 0);
            if (c < 2) step();
        end
        step();
        clken = 1;
        #1;
        check("post-stall waitrequest", DW'({a_s1_wr, a_s2_wr, b_s1_wr, b_s2_wr}), 0);
        check_lat1("post-stall", 1, 32'hDEADBEEF);
        step();
        check_lat2("post-stall", 1, 32'hDEADBEEF);
        step();
        check("post-stall once", DW'(a_s1_v | b_s1_v), 0);

        // reset_req blocks acceptance: a write attempted under it is lost.
        reset_req = 1;
        set_req(1, 1, 0, 15'd5, 4'hF, 32'h0);
        #1;
        check("reset_req waitrequest", DW'({a_s1_wr, a_s2_wr}), 2'b11);
        step();
        idle();
        reset_req = 0;
        do_read("reset_req no write", 1, 15'd5, 32'hDEADBEEF);

        // Reset during an in-flight read discards it.
        set_req(2, 0, 1, 15'd5, 4'hF, '0);
        step();
        idle();
        reset = 1;
        #1;
        check("rst valid", DW'(a_s2_v | b_s2_v | a_s1_v | b_s1_v), 0);
        check("rst data", a_s2_rd | b_s2_rd | a_s1_rd | b_s1_rd, 0);
        check("rst collisions", DW'(a_coll | b_coll), 0);
        step();
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("rst no valid %0d", c), DW'(a_s2_v | b_s2_v), 0);
        end

        // Sustained collisions: count, then saturate.
        set_req(1, 1, 0, 15'd7, 4'hF, 32'h1);
        set_req(2, 1, 0, 15'd7, 4'hF, 32'h2);
        repeat (100) step();
        check("collisions 100", DW'(a_coll), 100);
        repeat (69900) step();
        idle();
        check("collisions sat L1", DW'(a_coll), 32'hFFFF);
        check("collisions sat L2", DW'(b_coll), 32'hFFFF);
        do_read("sat data", 1, 15'd7, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
